// File: rtl/and_response_checker.sv
// and_response_checker: on-chip receiving end of an AND-datapath test run.
// Tracks the operand stream fed into the datapath and computes a & b for each
// operand pair. It queues those expected values so that any DUT latency is
// tolerated, then compares them in order against the DUT responses.
// Results are pass/fail, a saturating error count, the first mismatch and a
// sticky protocol-error flag for FIFO overflow or orphan responses.
module and_response_checker #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] stim_a,
    input  logic [WIDTH-1:0] stim_b,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic             proto_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reference model of the datapath under test.
    function automatic logic [WIDTH-1:0] and_expect(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return a & b;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    fifo_cnt_r;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] vec_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] first_idx_r;
    logic [WIDTH-1:0] first_exp_r;
    logic [WIDTH-1:0] first_got_r;
    logic             proto_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic             in_run_s;
    logic             empty_s;
    logic             full_s;
    logic [WIDTH-1:0] stim_and_s;
    logic             pop_s;
    logic             bypass_s;
    logic             orphan_s;
    logic             push_s;
    logic             overflow_s;
    logic [WIDTH-1:0] exp_s;
    logic             err_s;
    logic [CNT_W-1:0] vec_next_s;
    logic [CNT_W-1:0] err_next_s;
    logic             proto_next_s;
    logic             last_s;

    // Decode FIFO push/pop, bypass and orphan cases and the compare result.
    always_comb begin
        in_run_s   = (state_r == RUN);
        empty_s    = (fifo_cnt_r == {CW{1'b0}});
        full_s     = (fifo_cnt_r == CW'(DEPTH));
        stim_and_s = and_expect(stim_a, stim_b);
        pop_s      = in_run_s && resp_valid && !empty_s;
        bypass_s   = in_run_s && resp_valid && empty_s && stim_valid;
        orphan_s   = in_run_s && resp_valid && empty_s && !stim_valid;
        // A bypassed operand is consumed immediately and never stored.
        push_s     = in_run_s && stim_valid && !bypass_s && (!full_s || pop_s);
        overflow_s = in_run_s && stim_valid && full_s && !pop_s;
        if (pop_s) begin
            exp_s = mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            exp_s = stim_and_s;
        end else begin
            exp_s = {WIDTH{1'b0}};
        end
        err_s      = in_run_s && resp_valid && (orphan_s || (exp_s != resp_out));
        vec_next_s = vec_count_r + CNT_W'(1);
        if (err_count_r == {CNT_W{1'b1}}) begin
            err_next_s = err_count_r;
        end else begin
            err_next_s = err_count_r + CNT_W'(1);
        end
        proto_next_s = proto_r || overflow_s || orphan_s;
        last_s       = in_run_s && resp_valid && (vec_next_s == num_r);
    end

    // Expected-value storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= stim_and_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Run-control FSM with FIFO pointers, counters and first-error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            fifo_cnt_r  <= {CW{1'b0}};
            num_r       <= {CNT_W{1'b0}};
            vec_count_r <= {CNT_W{1'b0}};
            err_count_r <= {CNT_W{1'b0}};
            first_idx_r <= {CNT_W{1'b0}};
            first_exp_r <= {WIDTH{1'b0}};
            first_got_r <= {WIDTH{1'b0}};
            proto_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        wr_ptr_r    <= {AW{1'b0}};
                        rd_ptr_r    <= {AW{1'b0}};
                        fifo_cnt_r  <= {CW{1'b0}};
                        num_r       <= num_vectors;
                        vec_count_r <= {CNT_W{1'b0}};
                        err_count_r <= {CNT_W{1'b0}};
                        first_idx_r <= {CNT_W{1'b0}};
                        first_exp_r <= {WIDTH{1'b0}};
                        first_got_r <= {WIDTH{1'b0}};
                        proto_r     <= 1'b0;
                        // An empty run completes immediately and trivially passes.
                        if (num_vectors == {CNT_W{1'b0}}) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                            pass_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                RUN: begin
                    if (last_s) begin
                        // Leftover expected entries are discarded, not errors.
                        wr_ptr_r   <= {AW{1'b0}};
                        rd_ptr_r   <= {AW{1'b0}};
                        fifo_cnt_r <= {CW{1'b0}};
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        pass_r     <= !err_s && (err_count_r == {CNT_W{1'b0}}) && !proto_next_s;
                    end else begin
                        if (push_s) begin
                            wr_ptr_r <= wr_ptr_r + AW'(1);
                        end else begin
                            wr_ptr_r <= wr_ptr_r;
                        end
                        if (pop_s) begin
                            rd_ptr_r <= rd_ptr_r + AW'(1);
                        end else begin
                            rd_ptr_r <= rd_ptr_r;
                        end
                        case ({push_s, pop_s})
                            2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                            2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                            default: fifo_cnt_r <= fifo_cnt_r;
                        endcase
                    end
                    if (resp_valid) begin
                        vec_count_r <= vec_next_s;
                    end else begin
                        vec_count_r <= vec_count_r;
                    end
                    if (err_s) begin
                        err_count_r <= err_next_s;
                        // Only the first error of a run is captured.
                        if (err_count_r == {CNT_W{1'b0}}) begin
                            first_idx_r <= vec_count_r;
                            first_exp_r <= exp_s;
                            first_got_r <= resp_out;
                        end else begin
                            first_idx_r <= first_idx_r;
                        end
                    end else begin
                        err_count_r <= err_count_r;
                    end
                    proto_r <= proto_next_s;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_count_r;
    assign vec_count     = vec_count_r;
    assign first_err_idx = first_idx_r;
    assign first_err_exp = first_exp_r;
    assign first_err_got = first_got_r;
    assign proto_err     = proto_r;

endmodule

// File: tb/tb_and_response_checker.sv
// Scoreboard bench for and_response_checker: each run pushes its expected
// final result; a monitor pops and compares whenever done rises.
module tb_and_response_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vectors;
    logic        stim_valid;
    logic [1:0]  stim_a;
    logic [1:0]  stim_b;
    logic        resp_valid;
    logic [1:0]  resp_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] vec_count;
    logic [15:0] first_err_idx;
    logic [1:0]  first_err_exp;
    logic [1:0]  first_err_got;
    logic        proto_err;

    and_response_checker #(.WIDTH(2), .DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_b(stim_b),
        .resp_valid(resp_valid), .resp_out(resp_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .vec_count(vec_count), .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [15:0] vec;
        logic [15:0] idx;
        logic [1:0]  fexp;
        logic [1:0]  fgot;
        logic        proto;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic        done_q = 1'b0;
    int          bypass_cnt = 0;
    int          peak = 0;
    logic [1:0]  va[5];
    logic [1:0]  vb[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input int e, input int v, input int i,
                                input logic [1:0] fe, input logic [1:0] fg, input logic pe);
        exp_t r;
        r.pass = p; r.err = 16'(e); r.vec = 16'(v); r.idx = 16'(i);
        r.fexp = fe; r.fgot = fg; r.proto = pe;
        return r;
    endfunction

    // Monitor: compares final run state against the scoreboard when done rises.
    always @(negedge clk) begin
        if (rst_n && done && !done_q) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_pass",  {31'd0, pass},           {31'd0, e.pass});
                check("mon_err",   {16'd0, err_count},      {16'd0, e.err});
                check("mon_vec",   {16'd0, vec_count},      {16'd0, e.vec});
                check("mon_idx",   {16'd0, first_err_idx},  {16'd0, e.idx});
                check("mon_fexp",  {30'd0, first_err_exp},  {30'd0, e.fexp});
                check("mon_fgot",  {30'd0, first_err_got},  {30'd0, e.fgot});
                check("mon_proto", {31'd0, proto_err},      {31'd0, e.proto});
            end
        end
        if (dut.bypass_s) bypass_cnt <= bypass_cnt + 1;
        if (int'(dut.fifo_cnt_r) > peak) peak <= int'(dut.fifo_cnt_r);
        done_q <= done;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        start = 1'b1;
        num_vectors = 16'(n);
        cyc();
        start = 1'b0;
    endtask

    task automatic run_vec(input int n, input int lat, input int bad_idx, input logic [1:0] bad_val);
        for (int t = 0; t < n + lat; t++) begin
            stim_valid = (t < n);
            stim_a = (t < n) ? va[t] : 2'b00;
            stim_b = (t < n) ? vb[t] : 2'b00;
            if (t >= lat) begin
                resp_valid = 1'b1;
                resp_out = ((t - lat) == bad_idx) ? bad_val : (va[t - lat] & vb[t - lat]);
            end else begin
                resp_valid = 1'b0;
                resp_out = 2'b00;
            end
            cyc();
        end
        stim_valid = 1'b0;
        resp_valid = 1'b0;
        stim_a = 2'b00;
        stim_b = 2'b00;
        resp_out = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        va = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
        vb = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10};
        rst_n = 1'b0; start = 1'b0; num_vectors = 16'd0;
        stim_valid = 1'b0; stim_a = 2'b00; stim_b = 2'b00;
        resp_valid = 1'b0; resp_out = 2'b00;
        repeat (2) cyc();
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_done",  {31'd0, done},      32'd0);
        check("rst_pass",  {31'd0, pass},      32'd0);
        check("rst_err",   {16'd0, err_count}, 32'd0);
        check("rst_vec",   {16'd0, vec_count}, 32'd0);
        check("rst_proto", {31'd0, proto_err}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Run 1: zero latency, every response takes the bypass path.
        sb.push_back(mk(1'b1, 0, 5, 0, 2'b00, 2'b00, 1'b0));
        start_run(5);
        bypass_cnt = 0;
        run_vec(5, 0, -1, 2'b00);
        check("r1_done_latency", {31'd0, done}, 32'd1);
        check("r1_bypass_count", 32'(bypass_cnt), 32'd5);
        repeat (2) cyc();

        // Run 2: responses delayed three cycles.
        sb.push_back(mk(1'b1, 0, 5, 0, 2'b00, 2'b00, 1'b0));
        start_run(5);
        peak = 0;
        run_vec(5, 3, -1, 2'b00);
        check("r2_done_latency", {31'd0, done}, 32'd1);
        check("r2_fifo_peak", 32'(peak), 32'd3);
        repeat (2) cyc();

        // Run 3: third response corrupted to 01 (expected 11).
        sb.push_back(mk(1'b0, 1, 5, 2, 2'b11, 2'b01, 1'b0));
        start_run(5);
        run_vec(5, 0, 2, 2'b01);
        check("r3_done_latency", {31'd0, done}, 32'd1);
        repeat (2) cyc();

        // Run 4: nine pushes into an eight-deep FIFO, then eight good responses.
        sb.push_back(mk(1'b0, 0, 8, 0, 2'b00, 2'b00, 1'b1));
        start_run(8);
        for (int t = 0; t < 9; t++) begin
            stim_valid = 1'b1;
            stim_a = 2'(t);
            stim_b = 2'b11;
            cyc();
            if (t == 7) check("r4_proto_before_ovf", {31'd0, proto_err}, 32'd0);
            if (t == 8) check("r4_proto_after_ovf",  {31'd0, proto_err}, 32'd1);
        end
        stim_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            resp_valid = 1'b1;
            resp_out = 2'(t);
            cyc();
        end
        resp_valid = 1'b0;
        check("r4_done", {31'd0, done}, 32'd1);
        repeat (2) cyc();

        // Run 5: orphan response with empty FIFO and no stimulus.
        sb.push_back(mk(1'b0, 1, 1, 0, 2'b00, 2'b10, 1'b1));
        start_run(1);
        resp_valid = 1'b1;
        resp_out = 2'b10;
        cyc();
        resp_valid = 1'b0;
        check("r5_done", {31'd0, done}, 32'd1);
        repeat (2) cyc();

        // Run 6: reset mid-run, then an empty run, then re-arm from DONE.
        start_run(5);
        run_vec(2, 0, -1, 2'b00);
        check("r6_vec_before_rst", {16'd0, vec_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("r6_rst_busy",  {31'd0, busy},      32'd0);
        check("r6_rst_done",  {31'd0, done},      32'd0);
        check("r6_rst_vec",   {16'd0, vec_count}, 32'd0);
        check("r6_rst_err",   {16'd0, err_count}, 32'd0);
        check("r6_rst_proto", {31'd0, proto_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        sb.push_back(mk(1'b1, 0, 0, 0, 2'b00, 2'b00, 1'b0));
        start_run(0);
        check("r6_zero_done", {31'd0, done}, 32'd1);
        check("r6_zero_pass", {31'd0, pass}, 32'd1);
        repeat (2) cyc();
        sb.push_back(mk(1'b1, 0, 2, 0, 2'b00, 2'b00, 1'b0));
        start_run(2);
        check("r6_rearm_busy", {31'd0, busy},      32'd1);
        check("r6_rearm_done", {31'd0, done},      32'd0);
        check("r6_rearm_vec",  {16'd0, vec_count}, 32'd0);
        run_vec(2, 0, -1, 2'b00);
        check("r6_rearm_finish", {31'd0, done}, 32'd1);
        repeat (3) cyc();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/and_response_checker.md
Name: and_response_checker

Overview:
- Synthesizable response checker for the bitwise-AND datapath.
- Receives the operand stream driven into the DUT and the DUT's output stream, and computes expected = a & b.
- Buffers expected values in a FIFO so that arbitrary DUT latency is tolerated. Compares them in order against DUT results.
- Reports pass/fail, error count and first-mismatch capture on debug outputs. This is the on-chip receiving end of the stimulus sequences used in HPF_tests.

Parameters:
- WIDTH, 2, bit width of operands and DUT output.
- DEPTH, 8, expected-value FIFO entries (power of two, ≥2).
- CNT_W, 16, width of vector/error counters and num_vectors.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a test run.
- num_vectors  in  CNT_W  vectors expected in the run; sampled on start.
- stim_valid  in  1  operands presented to DUT this cycle.
- stim_a  in  WIDTH  operand a.
- stim_b  in  WIDTH  operand b.
- resp_valid  in  1  DUT output valid this cycle.
- resp_out  in  WIDTH  DUT output.
- busy  out  1  run in progress.
- done  out  1  run complete (level, held until next start).
- pass  out  1  valid when done: err_count==0 and no protocol error.
- err_count  out  CNT_W  mismatches plus orphan responses, saturating.
- vec_count  out  CNT_W  responses consumed in current run.
- first_err_idx  out  CNT_W  vec_count value at first error.
- first_err_exp  out  WIDTH  expected value at first error.
- first_err_got  out  WIDTH  received value at first error.
- proto_err  out  1  sticky: FIFO overflow or orphan response.

Behaviour:
- Reset (rst_n low, async): state IDLE; FIFO empty; all outputs 0.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(vec_count reaches latched num_vectors)--> DONE.
  - DONE --start--> RUN.
  - start in RUN is ignored.
- On accepted start:
  - Clear counters, first_err_* fields, proto_err and FIFO.
  - Latch num_vectors.
  - If num_vectors==0, go to DONE on the next edge with pass=1.
- busy=1 only in RUN. done=1 only in DONE. pass is registered on entry to DONE.
- stim_valid and resp_valid are ignored outside RUN.
- Push (RUN, stim_valid): write stim_a & stim_b into FIFO.
  - If FIFO is full and there is no pop this cycle, drop the entry and set proto_err.
  - Full with simultaneous pop: accepted.
- Pop/compare (RUN, resp_valid):
  - Expected = FIFO head.
  - If FIFO is empty but stim_valid is high the same cycle, bypass: expected = stim_a & stim_b, and nothing is stored.
  - If FIFO is empty with no bypass (orphan response): counts as an error with first_err_exp = 0, and sets proto_err.
  - Every response increments vec_count.
  - Mismatch or orphan: err_count += 1, saturating at all-ones.
  - On the first error only, capture idx = pre-increment vec_count, plus exp and got.
- Latency:
  - Counters and first_err_* update on the edge after resp_valid.
  - done rises on the edge after the final compare, i.e. the edge on which vec_count becomes num_vectors.
- Entries left in the FIFO at DONE are discarded. They are not errors.
- Reset mid-run aborts immediately to IDLE with all outputs cleared.
- Comparison is full-width equality. No X-handling is required.

Test Plan:
- Zero latency, WIDTH=2, num_vectors=5.
  - Stimulus (a,b) pairs each with resp_out=a&b in the same cycle: (00,00),(11,01),(11,11),(11,00),(11,10).
  - Required: bypass path used; done=1 one cycle after 5th response; pass=1; err_count=0; vec_count=5.
- Same vectors, resp_out delayed 3 cycles.
  - Required: FIFO occupancy peaks at 3; pass=1; err_count=0.
- Same vectors with 3rd response forced to 01 instead of 11.
  - Required: err_count=1; first_err_idx=2; first_err_exp=11; first_err_got=01; pass=0.
- DEPTH=8, 9 stim_valid with no responses.
  - Required: proto_err=1 after the 9th.
  - Then 8 correct responses with num_vectors=8: err_count=0 and pass=0, because of proto_err.
- Response with empty FIFO and stim_valid=0.
  - Required: err_count=1; proto_err=1; first_err_exp=00.
- Assert rst_n low mid-run after 2 vectors.
  - Required: busy, done and counters are 0 immediately.
  - start with num_vectors=0 → done=1 and pass=1 next cycle.
  - A second start from DONE re-arms the run (busy=1, counters cleared).
